// File: rtl/mult_share_arbiter.sv
// mult_share_arbiter: round-robin sharing of one external 8x8 shift-add multiplier
// between N_REQ requesters. One operation is in flight at a time: accept an operand
// pair, pulse mul_start, wait for mul_done, then present the tagged product on the
// response channel until it is consumed.
//
// Optional build macro MULT_SHARE_WATCHDOG_EN adds a BUSY-state watchdog that aborts
// an operation after TIMEOUT cycles without mul_done, returning a zero product with
// rsp_err set. Without the macro BUSY waits indefinitely and rsp_err is tied low.

module mult_share_arbiter #(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned IDW     = 2,
  parameter int unsigned TIMEOUT = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req_valid,
  output logic [N_REQ-1:0]   req_ready,
  input  logic [8*N_REQ-1:0] req_b,
  input  logic [8*N_REQ-1:0] req_q,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [15:0]        rsp_result,
  output logic [IDW-1:0]     rsp_id,
  output logic               rsp_err,
  output logic               mul_start,
  output logic [7:0]         mul_b,
  output logic [7:0]         mul_q,
  input  logic [15:0]        mul_result,
  input  logic               mul_done
);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StStart = 2'd1,
    StBusy  = 2'd2,
    StResp  = 2'd3
  } state_e;

  state_e         state_q, state_d;
  logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0] id_q, id_d;
  logic [7:0]     mul_b_q, mul_b_d;
  logic [7:0]     mul_q_q, mul_q_d;
  logic [15:0]    result_q, result_d;

`ifdef MULT_SHARE_WATCHDOG_EN
  localparam int unsigned WdW = $clog2(TIMEOUT + 1);

  logic [WdW-1:0] wd_q, wd_d;
  logic           err_q, err_d;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT != 32'd0);
`endif

  // Per-requester operand lanes, split once so the grant mux indexes an array.
  logic [7:0] lane_b [N_REQ];
  logic [7:0] lane_q [N_REQ];

  for (genvar i = 0; i < N_REQ; i++) begin : g_lanes
    assign lane_b[i] = req_b[8*i +: 8];
    assign lane_q[i] = req_q[8*i +: 8];
  end

  logic           grant_found;
  logic [IDW-1:0] grant_idx;
  logic [IDW-1:0] grant_next;

  // Round-robin search: first valid requester at or after rr_ptr, wrapping at N_REQ.
  always_comb begin
    int unsigned    cand;
    logic [IDW-1:0] cand_id;
    cand        = 0;
    cand_id     = '0;
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      cand = 32'(rr_ptr_q) + k;
      if (cand >= N_REQ) begin
        cand = cand - N_REQ;
      end
      cand_id = IDW'(cand);
      if (!grant_found && req_valid[cand_id]) begin
        grant_found = 1'b1;
        grant_idx   = cand_id;
      end
    end
  end

  // Pointer moves one past the winner so the winner becomes lowest priority.
  always_comb begin
    grant_next = grant_idx + 1'b1;
    if (grant_idx == IDW'(N_REQ - 1)) begin
      grant_next = '0;
    end
  end

  // Ready is only offered in IDLE, and only to the round-robin winner.
  always_comb begin
    req_ready = '0;
    if (state_q == StIdle && grant_found) begin
      req_ready[grant_idx] = 1'b1;
    end
  end

  // Next-state and datapath register updates.
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    id_d     = id_q;
    mul_b_d  = mul_b_q;
    mul_q_d  = mul_q_q;
    result_d = result_q;
`ifdef MULT_SHARE_WATCHDOG_EN
    wd_d     = wd_q;
    err_d    = err_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (grant_found) begin
          mul_b_d  = lane_b[grant_idx];
          mul_q_d  = lane_q[grant_idx];
          id_d     = grant_idx;
          rr_ptr_d = grant_next;
`ifdef MULT_SHARE_WATCHDOG_EN
          err_d    = 1'b0;
`endif
          state_d  = StStart;
        end
      end
      StStart: begin
        // A mul_done seen here belongs to nothing we issued; it is dropped.
`ifdef MULT_SHARE_WATCHDOG_EN
        wd_d    = '0;
`endif
        state_d = StBusy;
      end
      StBusy: begin
        if (mul_done) begin
          result_d = mul_result;
          state_d  = StResp;
`ifdef MULT_SHARE_WATCHDOG_EN
        end else if (wd_q == WdW'(TIMEOUT - 1)) begin
          // Last permitted BUSY cycle expired without a result: abort.
          result_d = 16'h0000;
          err_d    = 1'b1;
          state_d  = StResp;
        end else begin
          wd_d = wd_q + 1'b1;
`endif
        end
      end
      StResp: begin
        if (rsp_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      rr_ptr_q <= '0;
      id_q     <= '0;
      mul_b_q  <= '0;
      mul_q_q  <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      id_q     <= id_d;
      mul_b_q  <= mul_b_d;
      mul_q_q  <= mul_q_d;
      result_q <= result_d;
    end
  end

`ifdef MULT_SHARE_WATCHDOG_EN
  // Watchdog counter and abort flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      wd_q  <= '0;
      err_q <= 1'b0;
    end else begin
      wd_q  <= wd_d;
      err_q <= err_d;
    end
  end

  assign rsp_err = err_q;
`else
  assign rsp_err = 1'b0;
`endif

  assign rsp_valid  = (state_q == StResp);
  assign mul_start  = (state_q == StStart);
  assign rsp_result = result_q;
  assign rsp_id     = id_q;
  assign mul_b      = mul_b_q;
  assign mul_q      = mul_q_q;

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Bench for mult_share_arbiter: directed and randomized operations against a
// round-robin reference model; the bench also plays the role of the multiplier.

module tb_mult_share_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned TO = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic [N-1:0]      req_valid;
  logic [N-1:0]      req_ready;
  logic [8*N-1:0]    req_b;
  logic [8*N-1:0]    req_q;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [15:0]       rsp_result;
  logic [1:0]        rsp_id;
  logic              rsp_err;
  logic              mul_start;
  logic [7:0]        mul_b;
  logic [7:0]        mul_q;
  logic [15:0]       mul_result;
  logic              mul_done;

  mult_share_arbiter #(
    .N_REQ  (N),
    .IDW    (2),
    .TIMEOUT(TO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_b     (req_b),
    .req_q     (req_q),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_result(rsp_result),
    .rsp_id    (rsp_id),
    .rsp_err   (rsp_err),
    .mul_start (mul_start),
    .mul_b     (mul_b),
    .mul_q     (mul_q),
    .mul_result(mul_result),
    .mul_done  (mul_done)
  );

  always #5 clk = ~clk;

  int unsigned errors = 0;
  int unsigned checks = 0;

  // Reference model state: round-robin pointer and the requesters' pending operands.
  int          rr = 0;
  logic [7:0]  b_arr [N];
  logic [7:0]  q_arr [N];
  logic [N-1:0] vmask;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    req_valid = vmask;
    for (int i = 0; i < N; i++) begin
      req_b[8*i +: 8] = b_arr[i];
      req_q[8*i +: 8] = q_arr[i];
    end
  endtask

  function automatic int pick(input int ptr, input logic [N-1:0] v);
    int idx;
    for (int k = 0; k < N; k++) begin
      idx = (ptr + k) % N;
      if (v[idx[1:0]]) return idx;
    end
    return -1;
  endfunction

  // One full operation starting in IDLE: grant, start, BUSY for lat+1 cycles, response.
  task automatic run_op(input int lat, input int hold, input bit glitch, input bit keep,
                        input bit always_rdy);
    int          g;
    logic [7:0]  eb;
    logic [7:0]  eq;
    logic [15:0] ep;
    if (vmask == '0) vmask[0] = 1'b1;
    drive();
    #1;
    g  = pick(rr, vmask);
    eb = b_arr[g[1:0]];
    eq = q_arr[g[1:0]];
    ep = 16'(eb) * 16'(eq);
    chk("grant_ready", 32'(req_ready), 32'(1 << g));
    chk("idle_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("idle_start", 32'(mul_start), 32'd0);
    rr = (g + 1) % N;
    @(negedge clk);
    if (keep) begin
      b_arr[g[1:0]] = 8'($urandom);
      q_arr[g[1:0]] = 8'($urandom);
    end else begin
      vmask[g[1:0]] = 1'b0;
    end
    drive();
    mul_done   = glitch;
    mul_result = 16'hDEAD;
    #1;
    chk("start_pulse", 32'(mul_start), 32'd1);
    chk("start_b", 32'(mul_b), 32'(eb));
    chk("start_q", 32'(mul_q), 32'(eq));
    chk("start_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    mul_done = 1'b0;
    #1;
    for (int c = 0; c <= lat; c++) begin
      chk("busy_start", 32'(mul_start), 32'd0);
      chk("busy_operands", 32'({mul_b, mul_q}), 32'({eb, eq}));
      chk("busy_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("busy_ready", 32'(req_ready), 32'd0);
      if (c < lat) begin
        @(negedge clk);
        #1;
      end
    end
    mul_done   = 1'b1;
    mul_result = ep;
    rsp_ready  = always_rdy;
    @(negedge clk);
    mul_done   = 1'b0;
    mul_result = 16'($urandom);
    #1;
    chk("rsp_valid", 32'(rsp_valid), 32'd1);
    chk("rsp_result", 32'(rsp_result), 32'(ep));
    chk("rsp_id", 32'(rsp_id), 32'(g));
    chk("rsp_err", 32'(rsp_err), 32'd0);
    chk("rsp_ready_block", 32'(req_ready), 32'd0);
    if (!always_rdy) begin
      for (int h = 0; h < hold; h++) begin
        @(negedge clk);
        #1;
        chk("hold_valid", 32'(rsp_valid), 32'd1);
        chk("hold_result", 32'(rsp_result), 32'(ep));
        chk("hold_id", 32'(rsp_id), 32'(g));
        chk("hold_ready", 32'(req_ready), 32'd0);
      end
      rsp_ready = 1'b1;
    end
    @(negedge clk);
    #1;
    chk("back_idle", 32'(rsp_valid), 32'd0);
    rsp_ready = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    rst        = 1'b1;
    vmask      = '0;
    rsp_ready  = 1'b0;
    mul_done   = 1'b0;
    mul_result = '0;
    for (int i = 0; i < N; i++) begin
      b_arr[i] = '0;
      q_arr[i] = '0;
    end
    drive();
    repeat (3) @(negedge clk);
    #1;
    chk("reset_ready", 32'(req_ready), 32'd0);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_result", 32'(rsp_result), 32'd0);
    chk("reset_id", 32'(rsp_id), 32'd0);
    chk("reset_err", 32'(rsp_err), 32'd0);
    chk("reset_start", 32'(mul_start), 32'd0);
    chk("reset_mul_b", 32'(mul_b), 32'd0);
    chk("reset_mul_q", 32'(mul_q), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    #1;
    chk("idle_no_req_ready", 32'(req_ready), 32'd0);
    chk("idle_no_req_start", 32'(mul_start), 32'd0);

    // All four requesters continuously valid: grants 0,1,2,3,0.
    vmask = 4'b1111;
    for (int i = 0; i < N; i++) begin
      b_arr[i] = 8'($urandom);
      q_arr[i] = 8'($urandom);
    end
    for (int n = 0; n < 5; n++) begin
      run_op(n, 0, 1'b0, 1'b1, 1'b1);
    end

    // Directed operand cases.
    vmask    = 4'b0001;
    b_arr[0] = 8'd13;
    q_arr[0] = 8'd11;
    run_op(2, 0, 1'b0, 1'b0, 1'b1);
    vmask    = 4'b0100;
    b_arr[2] = 8'hFF;
    q_arr[2] = 8'hFF;
    run_op(0, 1, 1'b1, 1'b0, 1'b0);
    vmask    = 4'b1000;
    b_arr[3] = 8'h00;
    q_arr[3] = 8'hA5;
    run_op(3, 0, 1'b0, 1'b0, 1'b1);

    // Ten cycles of response backpressure.
    vmask    = 4'b1010;
    b_arr[1] = 8'd200;
    q_arr[1] = 8'd77;
    run_op(1, 10, 1'b0, 1'b0, 1'b0);

`ifndef MULT_SHARE_WATCHDOG_EN
    // Slow multiplier: no watchdog, so BUSY must simply wait.
    vmask = 4'b0001;
    run_op(40, 0, 1'b0, 1'b0, 1'b1);
`endif

    // Reset pulsed while BUSY: operation dropped, pointer back to 0.
    vmask    = 4'b0100;
    b_arr[2] = 8'h5A;
    q_arr[2] = 8'h3C;
    drive();
    #1;
    chk("rst_pre_grant", 32'(req_ready), 32'h4);
    @(negedge clk);
    vmask = '0;
    drive();
    #1;
    chk("rst_pre_start", 32'(mul_start), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_mid_ready", 32'(req_ready), 32'd0);
    chk("rst_mid_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_mid_result", 32'(rsp_result), 32'd0);
    chk("rst_mid_id", 32'(rsp_id), 32'd0);
    chk("rst_mid_err", 32'(rsp_err), 32'd0);
    chk("rst_mid_start", 32'(mul_start), 32'd0);
    chk("rst_mid_operands", 32'({mul_b, mul_q}), 32'd0);
    rr = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #1;
      chk("rst_no_rsp", 32'(rsp_valid), 32'd0);
      chk("rst_no_start", 32'(mul_start), 32'd0);
    end
    vmask    = 4'b1001;
    b_arr[0] = 8'd9;
    q_arr[0] = 8'd7;
    run_op(1, 0, 1'b0, 1'b0, 1'b1);

    // Randomized traffic; odd iterations keep the leftover valid set to exercise wrap.
    for (int n = 0; n < 40; n++) begin
      if (n % 2 == 0 || vmask == '0) begin
        vmask = 4'($urandom_range(1, 15));
        for (int i = 0; i < N; i++) begin
          b_arr[i] = 8'($urandom);
          q_arr[i] = 8'($urandom);
        end
      end
      run_op(int'($urandom_range(0, 5)), int'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

`ifdef MULT_SHARE_WATCHDOG_EN
    // Withheld mul_done: abort after TO BUSY cycles; late done pulses ignored.
    vmask = 4'b0010;
    drive();
    #1;
    chk("wd_grant", 32'(req_ready), 32'(1 << pick(rr, vmask)));
    rr = 2;
    @(negedge clk);
    vmask = '0;
    drive();
    #1;
    chk("wd_start", 32'(mul_start), 32'd1);
    @(negedge clk);
    #1;
    for (int c = 0; c < TO; c++) begin
      chk("wd_busy", 32'(rsp_valid), 32'd0);
      @(negedge clk);
      #1;
    end
    chk("wd_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("wd_rsp_err", 32'(rsp_err), 32'd1);
    chk("wd_rsp_result", 32'(rsp_result), 32'd0);
    chk("wd_rsp_id", 32'(rsp_id), 32'd1);
    mul_done   = 1'b1;
    mul_result = 16'h1234;
    @(negedge clk);
    mul_done = 1'b0;
    #1;
    chk("wd_late_valid", 32'(rsp_valid), 32'd1);
    chk("wd_late_result", 32'(rsp_result), 32'd0);
    chk("wd_late_err", 32'(rsp_err), 32'd1);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    #1;
    chk("wd_idle", 32'(rsp_valid), 32'd0);
    mul_done = 1'b1;
    @(negedge clk);
    mul_done = 1'b0;
    #1;
    chk("wd_idle_done_rsp", 32'(rsp_valid), 32'd0);
    chk("wd_idle_done_start", 32'(mul_start), 32'd0);
    vmask    = 4'b0101;
    b_arr[2] = 8'd3;
    q_arr[2] = 8'd5;
    run_op(2, 0, 1'b0, 1'b0, 1'b1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mult_share_arbiter.md
Name: mult_share_arbiter

Overview:
Shares one 8x8 shift-add multiplier between N_REQ requesters using a round-robin policy.
- Accepts operand pairs over per-requester valid/ready handshakes.
- Sequences the multiplier with a start pulse, then waits for its done pulse.
- Returns the 16-bit product on a shared response channel tagged with the requester index.
- Sits between client blocks and the multiplier instance; the multiplier shares clk/rst with this block.

Parameters:
N_REQ, 4, number of requesters; legal range 2..8.
IDW, 2, width of rsp_id; must equal clog2(N_REQ).
TIMEOUT, 32, watchdog limit in cycles; used only when the optional feature is compiled in.

Ports:
clk  in  1  clock, rising-edge.
rst  in  1  synchronous, active-high reset.
req_valid  in  N_REQ  per-requester operand-valid.
req_ready  out  N_REQ  per-requester accept; at most one bit high.
req_b  in  8*N_REQ  multiplicand; requester i uses bits [8i+7:8i].
req_q  in  8*N_REQ  multiplier; requester i uses bits [8i+7:8i].
rsp_valid  out  1  response valid.
rsp_ready  in  1  response consumer accept.
rsp_result  out  16  product {A[7:0], Q}.
rsp_id  out  IDW  index of the requester that owns the response.
rsp_err  out  1  response aborted by watchdog; 0 when the feature is compiled out.
mul_start  out  1  one-cycle start pulse to the multiplier.
mul_b  out  8  operand B to the multiplier; held stable from start until done.
mul_q  out  8  operand Q to the multiplier; held stable from start until done.
mul_result  in  16  product from the multiplier; valid in the mul_done cycle.
mul_done  in  1  one-cycle completion pulse from the multiplier.

Behaviour:
- Reset (synchronous, active-high): state=IDLE, rr_ptr=0, all outputs 0, operand and result registers 0.
- States: IDLE, START, BUSY, RESP.
- IDLE:
  - Grant g = first i with req_valid[i]=1, searching from rr_ptr upward modulo N_REQ.
  - req_ready = onehot(g), combinational from req_valid and state.
  - If any request is pending: latch req_b[g] and req_q[g] into mul_b/mul_q, latch g into the id register, set rr_ptr=(g+1) mod N_REQ, go to START.
  - Handshake completes in that cycle (valid & ready).
- START: mul_start=1 for exactly one cycle; go to BUSY.
- BUSY:
  - Wait for mul_done.
  - In the mul_done cycle: latch mul_result into rsp_result, go to RESP.
  - A mul_done pulse arriving in START is ignored.
- RESP:
  - rsp_valid=1; rsp_result, rsp_id and rsp_err held stable until rsp_ready.
  - When rsp_valid & rsp_ready: go to IDLE. A new grant is possible the following cycle.
- Only one operation is in flight; req_ready=0 in START, BUSY and RESP.
- Fairness: a continuously asserted requester is granted at least once every N_REQ operations.
- Latency: accept to mul_start = 1 cycle; mul_done to rsp_valid = 1 cycle.
- Overhead: minimum 3 cycles per operation, plus multiplier latency and response backpressure.
- Simultaneous requests: only the round-robin winner gets ready; the others keep valid and must hold their operands.
- rsp_ready held high: IDLE is re-entered the cycle after RESP, with no bubble beyond one cycle.
- rst asserted in any state: the in-flight operation is dropped, no response is issued, and rr_ptr returns to 0.
- A requester deasserting req_valid without a handshake is legal and ignored.

Optional Feature:
Macro: MULT_SHARE_WATCHDOG_EN.
- Defined:
  - A cycle counter clears on entering BUSY and increments each BUSY cycle.
  - If it reaches TIMEOUT with no mul_done: rsp_result=16'h0000, rsp_err=1, go to RESP.
  - A late mul_done arriving after the abort is ignored in RESP and IDLE.
- Not defined: no counter; BUSY waits indefinitely; rsp_err is tied to 0.

Test Plan:
- Single request: req_valid=0001, b=8'd13, q=8'd11 -> req_ready=0001 the same cycle, mul_start one cycle later, rsp_result=16'd143, rsp_id=0.
- All four requesters valid from reset -> grants in order 0,1,2,3,0; each rsp_id matches its grant; rr_ptr wraps correctly.
- Operands 8'hFF x 8'hFF -> rsp_result=16'hFE01; operand 8'h00 x 8'hA5 -> 16'h0000.
- rsp_ready held 0 for 10 cycles in RESP -> rsp_valid, rsp_result and rsp_id stable; req_ready=0 throughout; completes on rsp_ready=1.
- rst pulsed for one cycle in BUSY -> all outputs 0 next cycle, no response, the next grant goes to requester 0 if valid.
- MULT_SHARE_WATCHDOG_EN defined, TIMEOUT=32, mul_done withheld -> after 32 BUSY cycles rsp_valid=1, rsp_err=1, rsp_result=0; a later mul_done is ignored.
